fpnew_cast_result_buffer: RTL and testbench

Output buffer that sits directly downstream of the FP-to-FP cast unit. It accepts cast results (result, status, extension bit, tag) on a valid/ready handshake and stores them in a small FIFO. It drives NaN-boxed, register-width results to the writeback arbiter. Optionally, it accumulates sticky fflags over all retired results.

---
 rtl/fpnew_pkg.sv | 26 ++
 rtl/fpnew_cast_buf_mem.sv | 34 +++
 rtl/fpnew_cast_result_buffer.sv | 169 ++++++++++++++++
 tb/tb_fpnew_cast_result_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the cast result buffer: the IEEE exception
// status word and width constants that the buffer builds its entry type from.
package fpnew_pkg;

  // Number of IEEE exception flags carried with every result.
  localparam int unsigned NUM_FP_STATUS = 5;

  // Width of the per-entry metadata that accompanies the result payload
  // (exception flags plus the NaN-box fill bit).
  localparam int unsigned CAST_BUF_META_WIDTH = NUM_FP_STATUS + 1;

  // IEEE exception flags, ordered MSB to LSB as in the fflags CSR.
  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  // Merge two status words; used to accumulate sticky exception flags.
  function automatic status_t status_merge(input status_t a, input status_t b);
    return status_t'(a | b);
  endfunction

endpackage

// File: rtl/fpnew_cast_buf_mem.sv
// Storage array for the cast result buffer: Depth entries, one synchronous
// write port and one asynchronous read port. Data is intentionally not reset;
// validity is tracked by the pointer/count logic in the parent.
module fpnew_cast_buf_mem #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  // Next array contents: unchanged except the addressed entry on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Array flops, no reset so the storage stays a plain register file.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpnew_cast_result_buffer.sv
// Output buffer downstream of the FP-to-FP cast unit. Results are queued in a
// small FIFO and presented NaN-boxed to register width for writeback.
// Optional sticky fflags accumulation is enabled by defining the macro
// FPNEW_CAST_FFLAGS_ACC_EN; without it fflags_o is constant zero.
module fpnew_cast_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned FLen     = 64,
  parameter int unsigned DstWidth = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned TagWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  // upstream (cast unit) side
  input  logic [DstWidth-1:0] in_result_i,
  input  status_t             in_status_i,
  input  logic                in_extension_bit_i,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  // downstream (writeback arbiter) side
  output logic [FLen-1:0]     out_result_o,
  output status_t             out_status_o,
  output logic [TagWidth-1:0] out_tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  // sticky flags and status
  output status_t             fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);

  // One stored cast result; width depends on the instance parameters.
  typedef struct packed {
    logic [DstWidth-1:0] result;
    status_t             status;
    logic                ext;
    logic [TagWidth-1:0] tag;
  } cast_buf_entry_t;

  localparam int unsigned EntryWidth = $bits(cast_buf_entry_t);

  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic            push;
  logic            pop;
  logic            mem_we;
  cast_buf_entry_t wr_entry;
  cast_buf_entry_t rd_entry;
  logic [EntryWidth-1:0] rd_bits;

  // Handshake flags come from the registered count only, so in_ready_o has
  // no combinational dependency on out_ready_i; a full buffer refuses a push
  // even in a cycle where the head is being popped.
  assign in_ready_o  = (count_q != FullCount);
  assign out_valid_o = (count_q != '0);
  assign busy_o      = (count_q != '0);

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // A flush drops any same-cycle push, so the write is suppressed as well.
  assign mem_we = push & ~flush_i;

  assign wr_entry = '{
    result: in_result_i,
    status: in_status_i,
    ext:    in_extension_bit_i,
    tag:    in_tag_i
  };

  // Pointer and occupancy update; flush empties the FIFO outright.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrWidth'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  fpnew_cast_buf_mem #(
    .Depth (Depth),
    .Width (EntryWidth)
  ) i_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_bits)
  );

  assign rd_entry     = cast_buf_entry_t'(rd_bits);
  assign out_status_o = rd_entry.status;
  assign out_tag_o    = rd_entry.tag;

  // NaN-box the narrow result up to register width using the stored fill bit.
  if (FLen > DstWidth) begin : gen_nanbox
    assign out_result_o = {{(FLen - DstWidth){rd_entry.ext}}, rd_entry.result};
  end else begin : gen_no_nanbox
    logic unused_ext;
    assign unused_ext   = rd_entry.ext;
    assign out_result_o = rd_entry.result;
  end

`ifdef FPNEW_CAST_FFLAGS_ACC_EN
  status_t fflags_q, fflags_d;

  // Sticky flags: clear first, then OR in the status of the entry leaving.
  always_comb begin
    fflags_d = fflags_clr_i ? status_t'('0) : fflags_q;
    if (pop) begin
      fflags_d = status_merge(fflags_d, rd_entry.status);
    end
  end

  // Accumulator flops; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_fpnew_cast_result_buffer.sv
// Self-checking bench for fpnew_cast_result_buffer (FLen=64, DstWidth=32,
// Depth=4). Expectations follow FPNEW_CAST_FFLAGS_ACC_EN if it is defined.
module tb_fpnew_cast_result_buffer;

  localparam int FLen     = 64;
  localparam int DstWidth = 32;
  localparam int Depth    = 4;
  localparam int TagWidth = 8;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic [DstWidth-1:0] in_result_i;
  logic [4:0]          in_status_i;
  logic                in_extension_bit_i;
  logic [TagWidth-1:0] in_tag_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [FLen-1:0]     out_result_o;
  logic [4:0]          out_status_o;
  logic [TagWidth-1:0] out_tag_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [4:0]          fflags_o;
  logic                fflags_clr_i;
  logic                busy_o;

  always #5 clk_i = ~clk_i;

  fpnew_cast_result_buffer #(
    .FLen     (FLen),
    .DstWidth (DstWidth),
    .Depth    (Depth),
    .TagWidth (TagWidth)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .in_result_i        (in_result_i),
    .in_status_i        (in_status_i),
    .in_extension_bit_i (in_extension_bit_i),
    .in_tag_i           (in_tag_i),
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .out_result_o       (out_result_o),
    .out_status_o       (out_status_o),
    .out_tag_o          (out_tag_o),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .fflags_o           (fflags_o),
    .fflags_clr_i       (fflags_clr_i),
    .busy_o             (busy_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    logic [7:0]  tag;
    logic        ordy;
    logic        flush;
    logic        clr;
    logic        chk;
    logic        exp_irdy;
    logic        exp_ovld;
  } vec_t;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  status;
    logic [7:0]  tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] model_fflags;
  int         checks;
  int         errors;
  vec_t       tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] result,
                              input logic [4:0] status, input logic ext,
                              input logic [7:0] tag, input logic ordy,
                              input logic flush, input logic clr, input logic chk,
                              input logic exp_irdy, input logic exp_ovld);
    vec_t v;
    v.valid = valid; v.result = result; v.status = status; v.ext = ext;
    v.tag = tag; v.ordy = ordy; v.flush = flush; v.clr = clr; v.chk = chk;
    v.exp_irdy = exp_irdy; v.exp_ovld = exp_ovld;
    return v;
  endfunction

  // One clock cycle: drive, sample at negedge against model, then advance model.
  task automatic run_cycle(input vec_t v, input string lbl);
    logic push, pop;
    exp_t item;
    exp_t head;
    in_valid_i         = v.valid;
    in_result_i        = v.result;
    in_status_i        = v.status;
    in_extension_bit_i = v.ext;
    in_tag_i           = v.tag;
    out_ready_i        = v.ordy;
    flush_i            = v.flush;
    fflags_clr_i       = v.clr;
    @(negedge clk_i);
    check({lbl, ".out_valid"}, 64'(out_valid_o), 64'(exp_q.size() != 0));
    check({lbl, ".in_ready"},  64'(in_ready_o),  64'(exp_q.size() != Depth));
    check({lbl, ".busy"},      64'(busy_o),      64'(exp_q.size() != 0));
    check({lbl, ".fflags"},    64'(fflags_o),    64'(model_fflags));
    if (v.chk) begin
      check({lbl, ".tbl_in_ready"},  64'(in_ready_o),  64'(v.exp_irdy));
      check({lbl, ".tbl_out_valid"}, 64'(out_valid_o), 64'(v.exp_ovld));
    end
    head = '{default: '0};
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check({lbl, ".result"}, out_result_o,        head.result);
      check({lbl, ".status"}, 64'(out_status_o),   64'(head.status));
      check({lbl, ".tag"},    64'(out_tag_o),      64'(head.tag));
    end
    push = v.valid && (exp_q.size() != Depth);
    pop  = v.ordy && (exp_q.size() != 0);
    @(posedge clk_i);
    #1;
`ifdef FPNEW_CAST_FFLAGS_ACC_EN
    if (v.clr) model_fflags = 5'b0;
    if (pop)   model_fflags = model_fflags | head.status;
`endif
    if (v.flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        item.result = {{32{v.ext}}, v.result};
        item.status = v.status;
        item.tag    = v.tag;
        exp_q.push_back(item);
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; fflags_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    model_fflags = 5'b0;
    check("reset.in_ready",  64'(in_ready_o),  64'(1));
    check("reset.out_valid", 64'(out_valid_o), 64'(0));
    check("reset.busy",      64'(busy_o),      64'(0));
    check("reset.fflags",    64'(fflags_o),    64'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_fflags = 5'b0;
    in_result_i = '0; in_status_i = '0; in_extension_bit_i = 1'b0; in_tag_i = '0;

    // NaN-box with ext=1 and ext=0, then fill/refuse/drain in order.
    tbl[0]  = mk(1, 32'h3F800000, 5'b00000, 1, 8'h12, 0, 0, 0, 1, 1, 0);
    tbl[1]  = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 1);
    tbl[2]  = mk(1, 32'h3F800000, 5'b00000, 0, 8'h13, 1, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 1);
    tbl[4]  = mk(0, 32'h0,        5'b00000, 0, 8'h00, 0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(1, 32'h11111111, 5'b00001, 1, 8'h01, 0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(1, 32'h22222222, 5'b00010, 0, 8'h02, 0, 0, 0, 1, 1, 1);
    tbl[7]  = mk(1, 32'h33333333, 5'b00100, 1, 8'h03, 0, 0, 0, 1, 1, 1);
    tbl[8]  = mk(1, 32'h44444444, 5'b01000, 0, 8'h04, 0, 0, 0, 1, 1, 1);
    tbl[9]  = mk(1, 32'h55555555, 5'b10000, 1, 8'h05, 0, 0, 0, 1, 0, 1);
    tbl[10] = mk(1, 32'h55555555, 5'b10000, 1, 8'h05, 1, 0, 0, 1, 0, 1);
    tbl[11] = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 1);
    tbl[12] = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 1);
    tbl[13] = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 1);
    tbl[14] = mk(0, 32'h0,        5'b00000, 0, 8'h00, 1, 0, 0, 1, 1, 0);

    do_reset();

    for (int i = 0; i < 15; i++) begin
      run_cycle(tbl[i], $sformatf("tbl%0d", i));
    end

    // Steady push+pop at count=2 with pointer wrap.
    run_cycle(mk(1, $urandom, 5'b00011, 1, 8'h20, 0, 0, 0, 1, 1, 0), "stream_fill0");
    run_cycle(mk(1, $urandom, 5'b00000, 0, 8'h21, 0, 0, 0, 1, 1, 1), "stream_fill1");
    for (int i = 0; i < 10; i++) begin
      run_cycle(mk(1, $urandom, 5'(i), i[0], 8'(8'h22 + i), 1, 0, 0, 1, 1, 1),
                $sformatf("stream%0d", i));
    end
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 1), "stream_drain0");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 1), "stream_drain1");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 0), "stream_empty");

    // Flush with 3 stored entries while a push is offered.
    run_cycle(mk(1, 32'hA0A0A0A0, 5'b00001, 1, 8'h50, 0, 0, 0, 1, 1, 0), "flush_fill0");
    run_cycle(mk(1, 32'hA1A1A1A1, 5'b00010, 0, 8'h51, 0, 0, 0, 1, 1, 1), "flush_fill1");
    run_cycle(mk(1, 32'hA2A2A2A2, 5'b00100, 1, 8'h52, 0, 0, 0, 1, 1, 1), "flush_fill2");
    run_cycle(mk(1, 32'hDEADBEEF, 5'b11111, 1, 8'h99, 0, 1, 0, 1, 1, 1), "flush_edge");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 0), "flush_after0");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 0), "flush_after1");
    // Flush coinciding with a pop: the popped status still accumulates.
    run_cycle(mk(1, 32'hB0B0B0B0, 5'b01000, 0, 8'h55, 0, 0, 0, 1, 1, 0), "flushpop_fill");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 1, 0, 1, 1, 1), "flushpop_edge");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 0), "flushpop_after");

    // Reset in the middle of traffic empties the buffer.
    run_cycle(mk(1, 32'hC0C0C0C0, 5'b00001, 1, 8'h70, 0, 0, 0, 1, 1, 0), "midrst_fill0");
    run_cycle(mk(1, 32'hC1C1C1C1, 5'b00010, 1, 8'h71, 0, 0, 0, 1, 1, 1), "midrst_fill1");
    do_reset();

    // Sticky flag accumulation and clear-with-pop.
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 0, 0, 1, 1, 1, 0), "ff_clear");
    run_cycle(mk(1, 32'h1, 5'b00001, 0, 8'h61, 0, 0, 0, 1, 1, 0), "ff_push0");
    run_cycle(mk(1, 32'h2, 5'b00110, 0, 8'h62, 0, 0, 0, 1, 1, 1), "ff_push1");
    run_cycle(mk(1, 32'h3, 5'b10000, 0, 8'h63, 0, 0, 0, 1, 1, 1), "ff_push2");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 1), "ff_pop0");
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 0, 1, 1, 1), "ff_pop1");
`ifdef FPNEW_CAST_FFLAGS_ACC_EN
    check("ff_accum", 64'(fflags_o), 64'(5'b00111));
`else
    check("ff_accum", 64'(fflags_o), 64'(0));
`endif
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 1, 0, 1, 1, 1, 1), "ff_clrpop");
`ifdef FPNEW_CAST_FFLAGS_ACC_EN
    check("ff_clrpop", 64'(fflags_o), 64'(5'b10000));
`else
    check("ff_clrpop", 64'(fflags_o), 64'(0));
`endif
    run_cycle(mk(0, 32'h0, 5'b0, 0, 8'h0, 0, 0, 0, 1, 1, 0), "ff_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
